ysyx_24100012_pc_ctrl: RTL and testbench

- Multi-cycle instruction sequencer and PC owner for the NPC core.
- Issues fetch requests to the IFU and accepts the instruction response. Waits for the execute-stage result, which carries the branch-comparator PC select and target, then computes and commits the next PC.
- Detects misaligned targets, fetch errors and halt (ebreak), and counts retired instructions.

---
 rtl/ysyx_24100012_pc_ctrl.sv | 137 +++++++++++++
 tb/tb_ysyx_24100012_pc_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_pc_ctrl.sv
// Multi-cycle instruction sequencer for the NPC core: owns the PC, drives IFU
// fetch handshakes, commits EXU redirects, and tracks traps, halt and retirement.
module ysyx_24100012_pc_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic                  ifu_rsp_err,
  output logic                  dec_start,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_pcsel,
  input  logic [ADDR_WIDTH-1:0] exu_target,
  input  logic                  exu_is_jalr,
  input  logic                  exu_halt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [ADDR_WIDTH-1:0] trap_addr,
  output logic                  halted,
  output logic [31:0]           retire_cnt
);

  typedef enum logic [2:0] {
    S_BOOT, S_REQ, S_WAIT_RSP, S_WAIT_EXU, S_HALT
  } state_t;

  localparam logic [1:0] CAUSE_FETCH = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc_inc, tgt, nxt;
  logic                  misalign;
  logic                  do_commit, do_retire, do_halt, do_trap;
  logic [1:0]            cause_n;
  logic [ADDR_WIDTH-1:0] taddr_n;

  assign pc_inc   = pc + ADDR_WIDTH'(4);
  assign tgt      = exu_is_jalr ? {exu_target[ADDR_WIDTH-1:1], 1'b0} : exu_target;
  assign nxt      = exu_pcsel ? tgt : pc_inc;
  assign misalign = |nxt[1:0];

  assign ifu_req_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_n;
  end

  // Handshake outputs depend on state only; inputs steer only next state and
  // the dec_start pulse.
  always_comb begin
    state_n       = state;
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    exu_ready     = 1'b0;
    dec_start     = 1'b0;
    do_commit     = 1'b0;
    do_retire     = 1'b0;
    do_halt       = 1'b0;
    do_trap       = 1'b0;
    cause_n       = 2'b00;
    taddr_n       = '0;
    unique case (state)
      S_BOOT: state_n = S_REQ;
      S_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) state_n = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        ifu_rsp_ready = 1'b1;
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            do_trap = 1'b1;
            do_halt = 1'b1;
            cause_n = CAUSE_FETCH;
            taddr_n = pc;
            state_n = S_HALT;
          end else begin
            dec_start = 1'b1;
            state_n   = S_WAIT_EXU;
          end
        end
      end
      S_WAIT_EXU: begin
        exu_ready = 1'b1;
        if (exu_valid) begin
          if (exu_halt) begin
            do_retire = 1'b1;
            do_halt   = 1'b1;
            state_n   = S_HALT;
          end else if (misalign) begin
            do_trap = 1'b1;
            do_halt = 1'b1;
            cause_n = CAUSE_ALIGN;
            taddr_n = nxt;
            state_n = S_HALT;
          end else begin
            do_commit = 1'b1;
            do_retire = 1'b1;
            state_n   = S_REQ;
          end
        end
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      retire_cnt <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      trap_addr  <= '0;
      halted     <= 1'b0;
    end else begin
      if (do_commit) pc <= nxt;
      if (do_retire) retire_cnt <= retire_cnt + 32'd1;
      if (do_halt)   halted <= 1'b1;
      // First trap wins; cause and address stay frozen afterwards.
      if (do_trap && !trap) begin
        trap       <= 1'b1;
        trap_cause <= cause_n;
        trap_addr  <= taddr_n;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_pc_ctrl.sv
// Directed per-cycle vector table for the default-PC instance, plus a
// hand-written wrap/halt sequence on an instance reset at 0xFFFFFFFC.
module tb_ysyx_24100012_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic        exu_valid, exu_pcsel, exu_is_jalr, exu_halt;
  logic [31:0] exu_target;

  logic        a_req_valid, a_rsp_ready, a_dec_start, a_exu_ready, a_trap, a_halted;
  logic [31:0] a_req_addr, a_pc, a_trap_addr, a_retire;
  logic [1:0]  a_cause;
  logic        b_req_valid, b_rsp_ready, b_dec_start, b_exu_ready, b_trap, b_halted;
  logic [31:0] b_req_addr, b_pc, b_trap_addr, b_retire;
  logic [1:0]  b_cause;

  always #5 clk = ~clk;

  ysyx_24100012_pc_ctrl #(.ADDR_WIDTH(32), .RESET_PC(32'h8000_0000)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(a_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(a_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(a_rsp_ready), .ifu_rsp_err(ifu_rsp_err),
    .dec_start(a_dec_start),
    .exu_valid(exu_valid), .exu_ready(a_exu_ready), .exu_pcsel(exu_pcsel),
    .exu_target(exu_target), .exu_is_jalr(exu_is_jalr), .exu_halt(exu_halt),
    .pc(a_pc), .trap(a_trap), .trap_cause(a_cause), .trap_addr(a_trap_addr),
    .halted(a_halted), .retire_cnt(a_retire)
  );

  ysyx_24100012_pc_ctrl #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(b_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(b_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(b_rsp_ready), .ifu_rsp_err(ifu_rsp_err),
    .dec_start(b_dec_start),
    .exu_valid(exu_valid), .exu_ready(b_exu_ready), .exu_pcsel(exu_pcsel),
    .exu_target(exu_target), .exu_is_jalr(exu_is_jalr), .exu_halt(exu_halt),
    .pc(b_pc), .trap(b_trap), .trap_cause(b_cause), .trap_addr(b_trap_addr),
    .halted(b_halted), .retire_cnt(b_retire)
  );

  typedef struct {
    logic        rst_n, rrdy, rsv, err, exv, sel, jalr, halt;
    logic [31:0] tgt;
    logic        rqv, rsr, dec, exr;
    logic [31:0] pc;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] taddr;
    logic        halted;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic v(input logic r, rr, rs, er, ev, sl, jr, ht, input logic [31:0] tg,
                   input logic qv, sr, dc, xr, input logic [31:0] p,
                   input logic tp, input logic [1:0] cs, input logic [31:0] ta,
                   input logic hd, input logic [31:0] rt);
    vec_t x;
    x.rst_n = r; x.rrdy = rr; x.rsv = rs; x.err = er; x.exv = ev;
    x.sel = sl; x.jalr = jr; x.halt = ht; x.tgt = tg;
    x.rqv = qv; x.rsr = sr; x.dec = dc; x.exr = xr; x.pc = p;
    x.trap = tp; x.cause = cs; x.taddr = ta; x.halted = hd; x.ret = rt;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, rr, rs, er, ev, sl, jr, ht, input logic [31:0] tg);
    rst_n = r; ifu_req_ready = rr; ifu_rsp_valid = rs; ifu_rsp_err = er;
    exu_valid = ev; exu_pcsel = sl; exu_is_jalr = jr; exu_halt = ht; exu_target = tg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] P0 = 32'h8000_0000;

  initial begin
    // rst rrdy rsv err exv sel jalr halt tgt | rqv rsr dec exr pc | trap cause taddr halted ret
    v(0,1,1,0,1,0,0,0,0,            0,0,0,0, P0,            0,0,0,0, 0); // 0 reset
    v(1,1,1,0,1,0,0,0,0,            0,0,0,0, P0,            0,0,0,0, 0); // 1 boot
    v(1,1,1,0,1,0,0,0,0,            1,0,0,0, P0,            0,0,0,0, 0); // 2 req
    v(1,1,1,0,1,0,0,0,0,            0,1,1,0, P0,            0,0,0,0, 0); // 3 rsp
    v(1,1,1,0,1,0,0,0,0,            0,0,0,1, P0,            0,0,0,0, 0); // 4 exu
    v(1,1,1,0,1,0,0,0,0,            1,0,0,0, 32'h8000_0004, 0,0,0,0, 1);
    v(1,1,1,0,1,0,0,0,0,            0,1,1,0, 32'h8000_0004, 0,0,0,0, 1);
    v(1,1,1,0,1,0,0,0,0,            0,0,0,1, 32'h8000_0004, 0,0,0,0, 1);
    v(1,1,1,0,1,0,0,0,0,            1,0,0,0, 32'h8000_0008, 0,0,0,0, 2);
    v(1,1,1,0,1,0,0,0,0,            0,1,1,0, 32'h8000_0008, 0,0,0,0, 2);
    v(1,1,1,0,1,0,0,0,0,            0,0,0,1, 32'h8000_0008, 0,0,0,0, 2);
    v(1,1,1,0,1,0,0,0,0,            1,0,0,0, 32'h8000_000C, 0,0,0,0, 3); // 11
    v(1,1,1,0,1,0,0,0,0,            0,1,1,0, 32'h8000_000C, 0,0,0,0, 3);
    v(1,1,1,0,1,1,0,0,32'h8000_0100,0,0,0,1, 32'h8000_000C, 0,0,0,0, 3); // taken branch
    v(1,1,1,0,1,0,0,0,0,            1,0,0,0, 32'h8000_0100, 0,0,0,0, 4);
    v(1,1,1,0,1,0,0,0,0,            0,1,1,0, 32'h8000_0100, 0,0,0,0, 4);
    v(1,1,1,0,1,1,1,0,32'h8000_0105,0,0,0,1, 32'h8000_0100, 0,0,0,0, 4); // jalr
    for (int i = 0; i < 5; i++)                                           // backpressure
      v(1,0,1,0,1,0,0,0,0,          1,0,0,0, 32'h8000_0104, 0,0,0,0, 5);
    v(1,1,1,0,1,0,0,0,0,            1,0,0,0, 32'h8000_0104, 0,0,0,0, 5); // accept + rsp same cycle
    v(1,1,0,0,1,0,0,0,0,            0,1,0,0, 32'h8000_0104, 0,0,0,0, 5); // rsp not captured
    v(1,1,1,0,1,0,0,0,0,            0,1,1,0, 32'h8000_0104, 0,0,0,0, 5);
    v(1,1,1,0,0,0,0,0,0,            0,0,0,1, 32'h8000_0104, 0,0,0,0, 5); // exu stall
    v(0,1,1,0,1,0,0,0,0,            0,0,0,0, P0,            0,0,0,0, 0); // async reset in WAIT_EXU
    v(1,1,1,0,1,0,0,0,0,            0,0,0,0, P0,            0,0,0,0, 0);
    v(1,1,1,0,1,0,0,0,0,            1,0,0,0, P0,            0,0,0,0, 0);
    v(1,1,1,0,1,0,0,0,0,            0,1,1,0, P0,            0,0,0,0, 0);
    v(1,1,1,0,1,1,1,0,32'h8000_0103,0,0,0,1, P0,            0,0,0,0, 0); // misaligned jalr
    v(1,1,1,0,1,0,0,0,0,            0,0,0,0, P0,            1,2,32'h8000_0102,1, 0);
    v(1,1,1,0,1,0,0,0,0,            0,0,0,0, P0,            1,2,32'h8000_0102,1, 0);
    v(0,1,1,0,1,0,0,0,0,            0,0,0,0, P0,            0,0,0,0, 0);
    v(1,1,1,0,1,0,0,0,0,            0,0,0,0, P0,            0,0,0,0, 0);
    v(1,1,1,0,1,0,0,0,0,            1,0,0,0, P0,            0,0,0,0, 0);
    v(1,1,1,1,1,0,0,0,0,            0,1,0,0, P0,            0,0,0,0, 0); // fetch error
    v(1,1,1,0,1,0,0,0,0,            0,0,0,0, P0,            1,1,P0,1, 0);
    v(1,1,1,0,1,0,0,0,0,            0,0,0,0, P0,            1,1,P0,1, 0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].rrdy, vecs[i].rsv, vecs[i].err, vecs[i].exv,
            vecs[i].sel, vecs[i].jalr, vecs[i].halt, vecs[i].tgt);
      #1;
      chk($sformatf("v%0d req_valid", i),  32'(a_req_valid), 32'(vecs[i].rqv));
      chk($sformatf("v%0d rsp_ready", i),  32'(a_rsp_ready), 32'(vecs[i].rsr));
      chk($sformatf("v%0d dec_start", i),  32'(a_dec_start), 32'(vecs[i].dec));
      chk($sformatf("v%0d exu_ready", i),  32'(a_exu_ready), 32'(vecs[i].exr));
      chk($sformatf("v%0d req_addr", i),   a_req_addr,       vecs[i].pc);
      chk($sformatf("v%0d pc", i),         a_pc,             vecs[i].pc);
      chk($sformatf("v%0d trap", i),       32'(a_trap),      32'(vecs[i].trap));
      chk($sformatf("v%0d trap_cause", i), 32'(a_cause),     32'(vecs[i].cause));
      chk($sformatf("v%0d trap_addr", i),  a_trap_addr,      vecs[i].taddr);
      chk($sformatf("v%0d halted", i),     32'(a_halted),    32'(vecs[i].halted));
      chk($sformatf("v%0d retire_cnt", i), a_retire,         vecs[i].ret);
      tick();
    end

    // Wrap and halt on the 0xFFFFFFFC instance.
    drive(0,1,1,0,1,0,0,0,0);
    tick();
    drive(1,1,1,0,1,0,0,0,0);
    tick();
    chk("wrap req_valid", 32'(b_req_valid), 32'd1);
    chk("wrap req_addr0", b_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    tick();
    chk("wrap req_addr1", b_req_addr, 32'h0000_0000);
    chk("wrap retire1",   b_retire,   32'd1);
    exu_halt = 1'b1;
    tick();
    tick();
    chk("halt exu_ready", 32'(b_exu_ready), 32'd1);
    tick();
    chk("halt halted",    32'(b_halted),    32'd1);
    chk("halt retire",    b_retire,         32'd2);
    chk("halt pc",        b_pc,             32'h0000_0000);
    chk("halt trap",      32'(b_trap),      32'd0);
    tick();
    chk("halt req_valid", 32'(b_req_valid), 32'd0);
    chk("halt still",     32'(b_halted),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
